// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback unit.
package wb_pkg;

   localparam int XLEN      = 32;
   localparam int REG_NUM_W = 4;
   localparam int WB_DEPTH  = 4;

   // One queued execute result. The load_done bit sits beside each entry as
   // a separate flag vector so it can be cleared by reset.
   typedef struct packed {
      logic [REG_NUM_W-1:0] rd_num;
      logic                 rd_en;
      logic [XLEN-1:0]      rd_data;
      logic                 pc_en;
      logic [XLEN-1:0]      pc_data;
      logic                 cpsr_en;
      logic [XLEN-1:0]      cpsr_data;
      logic                 is_load;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order result queue: payload storage, valid/load_done flags, pointers
// and entry count. Pointers wrap naturally because DEPTH is a power of two.
module wb_fifo import wb_pkg::*; #(
   parameter int DEPTH = WB_DEPTH,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  wb_entry_t        push_entry,
   input  logic             pop,
   input  logic             attach_en,
   input  logic [PW-1:0]    attach_idx,
   input  logic [XLEN-1:0]  attach_data,
   output wb_entry_t        entries [DEPTH],
   output logic [DEPTH-1:0] valid,
   output logic [DEPTH-1:0] done,
   output logic [PW-1:0]    rd_ptr,
   output logic [CW-1:0]    count
);

   logic [PW-1:0] wr_ptr;

   // Payload storage; a push only targets a free slot and an attach only a
   // valid one, so the two writes never collide.
   always_ff @(posedge clk) begin
      if (push) entries[wr_ptr] <= push_entry;
      if (attach_en) entries[attach_idx].rd_data <= attach_data;
   end

   // Flags, pointers and count; count moves by push minus pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid  <= '0;
         done   <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            valid[wr_ptr] <= 1'b1;
            done[wr_ptr]  <= 1'b0;
            wr_ptr        <= wr_ptr + PW'(1);
         end
         if (pop) begin
            valid[rd_ptr] <= 1'b0;
            rd_ptr        <= rd_ptr + PW'(1);
         end
         if (attach_en) done[attach_idx] <= 1'b1;
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/wb_unit.sv
// Writeback unit: queues execute results in order, attaches in-order load
// data, retires one entry per cycle onto registered register-file ports and
// answers hazard queries against everything still queued.
//
// Handshake: a result transfers on a rising clk edge where exe_valid and
// exe_ready are both high. exe_ready depends only on the registered count
// (and is low during reset), so a retire in the same cycle never frees
// space for a push into a full queue.
module wb_unit import wb_pkg::*; #(
   parameter int DEPTH = WB_DEPTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 exe_valid,
   output logic                 exe_ready,
   input  logic [REG_NUM_W-1:0] exe_rd_num,
   input  logic                 exe_rd_write_en,
   input  logic [XLEN-1:0]      exe_rd_data,
   input  logic                 exe_is_load,
   input  logic                 exe_pc_write_en,
   input  logic [XLEN-1:0]      exe_pc_data,
   input  logic                 exe_cpsr_write_en,
   input  logic [XLEN-1:0]      exe_cpsr_data,
   input  logic                 mem_load_valid,
   input  logic [XLEN-1:0]      mem_load_data,
   input  logic [REG_NUM_W-1:0] hz_rs_num,
   input  logic [REG_NUM_W-1:0] hz_rt_num,
   output logic                 hz_stall,
   output logic [REG_NUM_W-1:0] wb_rd_num,
   output logic                 wb_rd_write_en,
   output logic [XLEN-1:0]      wb_rd_in,
   output logic                 wb_pc_write_en,
   output logic [XLEN-1:0]      wb_pc_in,
   output logic                 wb_cpsr_write_en,
   output logic [XLEN-1:0]      wb_cpsr_in,
   output logic                 err_orphan_load,
   output logic [2:0]           occupancy
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   wb_entry_t        entries [DEPTH];
   wb_entry_t        head;
   wb_entry_t        push_entry;
   logic [DEPTH-1:0] valid;
   logic [DEPTH-1:0] done;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic             push;
   logic             retire;
   logic             pend_found;
   logic [PW-1:0]    pend_idx;
   logic [PW-1:0]    cand;
   logic             attach_en;

   assign exe_ready = !reset && (count < FULL);
   assign push      = exe_valid && exe_ready;
   assign occupancy = 3'(count);

   assign push_entry = '{rd_num:    exe_rd_num,
                         rd_en:     exe_rd_write_en,
                         rd_data:   exe_rd_data,
                         pc_en:     exe_pc_write_en,
                         pc_data:   exe_pc_data,
                         cpsr_en:   exe_cpsr_write_en,
                         cpsr_data: exe_cpsr_data,
                         is_load:   exe_is_load};

   // Head retires once it holds final data; load_done is the registered
   // flag, so a load attached this cycle retires on the next edge.
   assign head   = entries[rd_ptr];
   assign retire = valid[rd_ptr] && (!head.is_load || done[rd_ptr]);

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .push        (push),
      .push_entry  (push_entry),
      .pop         (retire),
      .attach_en   (attach_en),
      .attach_idx  (pend_idx),
      .attach_data (mem_load_data),
      .entries     (entries),
      .valid       (valid),
      .done        (done),
      .rd_ptr      (rd_ptr),
      .count       (count)
   );

   // Find the oldest load still waiting for data, scanning from the head.
   always_comb begin
      pend_found = 1'b0;
      pend_idx   = '0;
      cand       = '0;
      for (int k = 0; k < DEPTH; k++) begin
         cand = rd_ptr + PW'(k);
         if (!pend_found && valid[cand] && entries[cand].is_load && !done[cand]) begin
            pend_found = 1'b1;
            pend_idx   = cand;
         end
      end
   end

   assign attach_en = mem_load_valid && pend_found;

   // Stall while any queued result will still write a requested register.
   always_comb begin
      hz_stall = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!reset && valid[i] && entries[i].rd_en &&
             (entries[i].rd_num == hz_rs_num || entries[i].rd_num == hz_rt_num))
            hz_stall = 1'b1;
      end
   end

   // Sticky flag for load data that had no pending load to land in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_orphan_load <= 1'b0;
      else if (mem_load_valid && !pend_found) err_orphan_load <= 1'b1;
   end

   // Registered write ports: enables pulse for one cycle per retire, data
   // fields only change when their enable is set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_rd_num        <= '0;
         wb_rd_write_en   <= 1'b0;
         wb_rd_in         <= '0;
         wb_pc_write_en   <= 1'b0;
         wb_pc_in         <= '0;
         wb_cpsr_write_en <= 1'b0;
         wb_cpsr_in       <= '0;
      end else begin
         wb_rd_write_en   <= retire && head.rd_en;
         wb_pc_write_en   <= retire && head.pc_en;
         wb_cpsr_write_en <= retire && head.cpsr_en;
         if (retire && head.rd_en) begin
            wb_rd_num <= head.rd_num;
            wb_rd_in  <= head.rd_data;
         end
         if (retire && head.pc_en) wb_pc_in <= head.pc_data;
         if (retire && head.cpsr_en) wb_cpsr_in <= head.cpsr_data;
      end
   end

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: hand-computed expectations checked with
// immediate assertions, plus an expected queue of register writes.
module tb_wb_unit;

   logic        clk;
   logic        reset;
   logic        exe_valid;
   logic        exe_ready;
   logic [3:0]  exe_rd_num;
   logic        exe_rd_write_en;
   logic [31:0] exe_rd_data;
   logic        exe_is_load;
   logic        exe_pc_write_en;
   logic [31:0] exe_pc_data;
   logic        exe_cpsr_write_en;
   logic [31:0] exe_cpsr_data;
   logic        mem_load_valid;
   logic [31:0] mem_load_data;
   logic [3:0]  hz_rs_num;
   logic [3:0]  hz_rt_num;
   logic        hz_stall;
   logic [3:0]  wb_rd_num;
   logic        wb_rd_write_en;
   logic [31:0] wb_rd_in;
   logic        wb_pc_write_en;
   logic [31:0] wb_pc_in;
   logic        wb_cpsr_write_en;
   logic [31:0] wb_cpsr_in;
   logic        err_orphan_load;
   logic [2:0]  occupancy;

   int total = 0;
   int bad   = 0;
   logic [35:0] exp_q[$];

   wb_unit #(.DEPTH(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .exe_valid         (exe_valid),
      .exe_ready         (exe_ready),
      .exe_rd_num        (exe_rd_num),
      .exe_rd_write_en   (exe_rd_write_en),
      .exe_rd_data       (exe_rd_data),
      .exe_is_load       (exe_is_load),
      .exe_pc_write_en   (exe_pc_write_en),
      .exe_pc_data       (exe_pc_data),
      .exe_cpsr_write_en (exe_cpsr_write_en),
      .exe_cpsr_data     (exe_cpsr_data),
      .mem_load_valid    (mem_load_valid),
      .mem_load_data     (mem_load_data),
      .hz_rs_num         (hz_rs_num),
      .hz_rt_num         (hz_rt_num),
      .hz_stall          (hz_stall),
      .wb_rd_num         (wb_rd_num),
      .wb_rd_write_en    (wb_rd_write_en),
      .wb_rd_in          (wb_rd_in),
      .wb_pc_write_en    (wb_pc_write_en),
      .wb_pc_in          (wb_pc_in),
      .wb_cpsr_write_en  (wb_cpsr_write_en),
      .wb_cpsr_in        (wb_cpsr_in),
      .err_orphan_load   (err_orphan_load),
      .occupancy         (occupancy)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] rd, input logic rd_en, input logic [31:0] data,
                       input logic is_load, input logic pc_en, input logic [31:0] pc,
                       input logic cpsr_en, input logic [31:0] cpsr);
      exe_valid         = 1'b1;
      exe_rd_num        = rd;
      exe_rd_write_en   = rd_en;
      exe_rd_data       = data;
      exe_is_load       = is_load;
      exe_pc_write_en   = pc_en;
      exe_pc_data       = pc;
      exe_cpsr_write_en = cpsr_en;
      exe_cpsr_data     = cpsr;
      tick();
      exe_valid         = 1'b0;
   endtask

   task automatic load_done(input logic [31:0] data);
      mem_load_valid = 1'b1;
      mem_load_data  = data;
      tick();
      mem_load_valid = 1'b0;
   endtask

   // Scoreboard: every register write must match the front of exp_q.
   always @(negedge clk) begin
      if (!reset && wb_rd_write_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_rd_write", {28'h0, wb_rd_num, wb_rd_in}, 64'h0);
         end else begin
            check("rd_write_order", {28'h0, wb_rd_num, wb_rd_in}, {28'h0, exp_q.pop_front()});
         end
      end
   end

   initial begin
      reset = 1'b1;
      exe_valid = 1'b0; exe_rd_num = '0; exe_rd_write_en = 1'b0; exe_rd_data = '0;
      exe_is_load = 1'b0; exe_pc_write_en = 1'b0; exe_pc_data = '0;
      exe_cpsr_write_en = 1'b0; exe_cpsr_data = '0;
      mem_load_valid = 1'b0; mem_load_data = '0;
      hz_rs_num = 4'd15; hz_rt_num = 4'd15;

      // Reset state
      tick(); tick();
      check("rst_ready", exe_ready, 0);
      check("rst_stall", hz_stall, 0);
      check("rst_occ", occupancy, 0);
      check("rst_wb_en", wb_rd_write_en, 0);
      check("rst_err", err_orphan_load, 0);
      reset = 1'b0;
      #1;
      check("ready_after_rst", exe_ready, 1);

      // Simple ALU result, latency 1
      exp_q.push_back({4'd3, 32'h11});
      push(4'd3, 1'b1, 32'h11, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("t1_occ_after_push", occupancy, 1);
      check("t1_en_not_yet", wb_rd_write_en, 0);
      tick();
      check("t1_en", wb_rd_write_en, 1);
      check("t1_num", wb_rd_num, 3);
      check("t1_data", wb_rd_in, 32'h11);
      tick();
      check("t1_en_drop", wb_rd_write_en, 0);
      check("t1_data_hold", wb_rd_in, 32'h11);

      // Load then ALU: in-order retire and hazard tracking
      exp_q.push_back({4'd5, 32'hAB});
      exp_q.push_back({4'd6, 32'h22});
      push(4'd5, 1'b1, 32'hDEAD, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      push(4'd6, 1'b1, 32'h22, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      check("t2_occ", occupancy, 2);
      hz_rs_num = 4'd6; hz_rt_num = 4'd0;
      #1;
      check("t2_stall_rs6", hz_stall, 1);
      hz_rs_num = 4'd9; hz_rt_num = 4'd5;
      #1;
      check("t2_stall_rt5", hz_stall, 1);
      hz_rs_num = 4'd9; hz_rt_num = 4'd0;
      #1;
      check("t2_no_stall", hz_stall, 0);
      hz_rs_num = 4'd6;
      tick();
      check("t2_wait_en", wb_rd_write_en, 0);
      tick();
      load_done(32'hAB);
      check("t2_no_retire_on_attach", wb_rd_write_en, 0);
      check("t2_stall_attach", hz_stall, 1);
      tick();
      check("t2_rd5_num", wb_rd_num, 5);
      check("t2_rd5_data", wb_rd_in, 32'hAB);
      check("t2_stall_mid", hz_stall, 1);
      check("t2_occ_mid", occupancy, 1);
      tick();
      check("t2_rd6_num", wb_rd_num, 6);
      check("t2_rd6_data", wb_rd_in, 32'h22);
      check("t2_stall_clear", hz_stall, 0);
      check("t2_occ_empty", occupancy, 0);
      hz_rs_num = 4'd15; hz_rt_num = 4'd15;

      // Full queue of loads, push held off, wrap-around
      exp_q.push_back({4'd1, 32'h1111});
      exp_q.push_back({4'd2, 32'h2222});
      exp_q.push_back({4'd7, 32'h7777});
      exp_q.push_back({4'd8, 32'h8888});
      exp_q.push_back({4'd9, 32'h99});
      push(4'd1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      push(4'd2, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      push(4'd7, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      push(4'd8, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      check("t3_occ_full", occupancy, 4);
      check("t3_ready_full", exe_ready, 0);
      exe_valid = 1'b1; exe_rd_num = 4'd9; exe_rd_write_en = 1'b1;
      exe_rd_data = 32'h99; exe_is_load = 1'b0;
      tick();
      check("t3_held_off", occupancy, 4);
      load_done(32'h1111);
      check("t3_ready_attach", exe_ready, 0);
      tick();
      check("t3_occ_no_push_on_retire", occupancy, 3);
      check("t3_ready_after_retire", exe_ready, 1);
      tick();
      exe_valid = 1'b0;
      check("t3_occ_push", occupancy, 4);
      load_done(32'h2222);
      load_done(32'h7777);
      load_done(32'h8888);
      tick(); tick(); tick();
      check("t3_drained", occupancy, 0);
      check("t3_exp_q_empty", exp_q.size(), 0);

      // PC and CPSR writes in the same cycle
      push(4'd4, 1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h8000_0000);
      tick();
      check("t4_pc_en", wb_pc_write_en, 1);
      check("t4_pc", wb_pc_in, 32'h100);
      check("t4_cpsr_en", wb_cpsr_write_en, 1);
      check("t4_cpsr", wb_cpsr_in, 32'h8000_0000);
      check("t4_rd_en", wb_rd_write_en, 0);
      tick();
      check("t4_pc_en_drop", wb_pc_write_en, 0);
      check("t4_pc_hold", wb_pc_in, 32'h100);

      // Orphan load data
      load_done(32'h5555);
      check("t5_err_set", err_orphan_load, 1);
      tick(); tick();
      check("t5_err_sticky", err_orphan_load, 1);

      // Reset with three entries queued
      push(4'd10, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      push(4'd11, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      push(4'd12, 1'b1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      check("t6_occ3", occupancy, 3);
      hz_rs_num = 4'd10;
      #1;
      check("t6_stall_pre", hz_stall, 1);
      #1;
      reset = 1'b1;
      #1;
      check("t6_occ_rst", occupancy, 0);
      check("t6_ready_rst", exe_ready, 0);
      check("t6_stall_rst", hz_stall, 0);
      check("t6_err_rst", err_orphan_load, 0);
      check("t6_pc_rst", wb_pc_in, 0);
      check("t6_cpsr_rst", wb_cpsr_in, 0);
      check("t6_rd_in_rst", wb_rd_in, 0);
      tick();
      reset = 1'b0;
      #1;
      check("t6_ready_release", exe_ready, 1);
      check("t6_stall_release", hz_stall, 0);
      tick(); tick(); tick();
      check("t6_no_wb", wb_rd_write_en, 0);
      check("t6_occ_after", occupancy, 0);
      check("t6_exp_q_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
